dwa_element_selector: RTL



---
 rtl/dwa_element_selector.sv | 87 ++++++++
 1 files changed

// File: rtl/dwa_element_selector.sv
// dwa_element_selector: quantizes the notch-filter output to a unit-element level and drives a DWA-rotated element bank.
// Optional build macro DWA_SAT_COUNTER_EN adds a saturating clip counter (sat_count_o) with synchronous clear (sat_clr_i).
module dwa_element_selector #(
   parameter int IN_WIDTH = 64,
   parameter int NUM_ELEM = 8,
   parameter int SHIFT = 28,
   localparam int PTR_W = $clog2(NUM_ELEM)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic signed [IN_WIDTH-1:0] sample_i,
   input  logic                       valid_i,
`ifdef DWA_SAT_COUNTER_EN
   input  logic                       sat_clr_i,
   output logic [15:0]                sat_count_o,
`endif
   output logic [NUM_ELEM-1:0]        elem_en_o,
   output logic [PTR_W:0]             level_o,
   output logic [PTR_W-1:0]           ptr_o,
   output logic                       sat_o,
   output logic                       valid_o
);
   localparam int QW = IN_WIDTH + 1;
   logic signed [QW-1:0] q;
   logic [PTR_W:0] lvl;
   logic sat;
   logic s1_vld, s1_sat;
   logic [PTR_W:0] s1_lvl;
   logic [NUM_ELEM:0] ones;
   logic [NUM_ELEM-1:0] run;
   logic [2*NUM_ELEM-1:0] rot;
   logic [PTR_W-1:0] ptr_next;
   // Level mapping: floor-shift, recentre, clip to 0..NUM_ELEM
   always_comb begin
      q = ($signed({sample_i[IN_WIDTH-1], sample_i}) >>> SHIFT) + $signed(QW'(NUM_ELEM / 2));
      sat = (q < 0) || (q > $signed(QW'(NUM_ELEM)));
      lvl = (q < 0) ? '0 : (q > $signed(QW'(NUM_ELEM))) ? (PTR_W + 1)'(NUM_ELEM) : q[PTR_W:0];
   end
   // Contiguous run of s1_lvl ones rotated left by the pointer; a full run wraps back to the same pointer
   always_comb begin
      ones = (NUM_ELEM + 1)'(1) << s1_lvl;
      run = NUM_ELEM'(ones - (NUM_ELEM + 1)'(1));
      rot = {run, run} << ptr_o;
      ptr_next = ptr_o + s1_lvl[PTR_W-1:0];
   end
   // Stage 1: register quantized level and clip flag
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_vld <= 1'b0;
         s1_lvl <= '0;
         s1_sat <= 1'b0;
      end else begin
         s1_vld <= valid_i;
         if (valid_i) begin
            s1_lvl <= lvl;
            s1_sat <= sat;
         end
      end
   end
   // Stage 2: drive the element bank and advance the pointer; outputs hold on invalid cycles
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         elem_en_o <= '0;
         level_o <= '0;
         ptr_o <= '0;
         sat_o <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= s1_vld;
         if (s1_vld) begin
            elem_en_o <= rot[2*NUM_ELEM-1:NUM_ELEM];
            level_o <= s1_lvl;
            ptr_o <= ptr_next;
            sat_o <= s1_sat;
         end
      end
   end
`ifdef DWA_SAT_COUNTER_EN
   // Clip counter: clear wins over increment, sticks at all-ones
   always_ff @(posedge clk_i) begin
      if (reset_i || sat_clr_i)
         sat_count_o <= '0;
      else if (s1_vld && s1_sat && sat_count_o != 16'hFFFF)
         sat_count_o <= sat_count_o + 16'd1;
   end
`endif
endmodule
